// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered ID-stage control decoder with a
// destination-register scoreboard for data-hazard stalls.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   IF/ID handshake (in_ready is combinational)
//   mode, opcode, s_in,   instruction fields
//   i_in, rd, rn, rm,
//   two_src               rm is a real source operand
//   hold                  downstream stall, freezes every register
//   flush                 branch taken in EX, drops the ID instruction
//   out_valid             ID/EX holds a real instruction (0 = bubble)
//   exec_cmd, mem_read,   registered EX/MEM/WB controls, all 0 on a
//   mem_write, wb_en,     bubble
//   imm, b, s_out, out_rd
//   hazard                combinational data-hazard flag for ID
//
// Build option: define CTRL_FORWARDING_EN when an EX/MEM forwarding
// path exists; only load-use against the ID/EX entry then stalls.

module ctrl_decode_pipe #(
   parameter int REG_W     = 4,
   parameter int HAZ_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [3:0]       opcode,
   input  logic             s_in,
   input  logic             i_in,
   input  logic [REG_W-1:0] rd,
   input  logic [REG_W-1:0] rn,
   input  logic [REG_W-1:0] rm,
   input  logic             two_src,
   input  logic             hold,
   input  logic             flush,
   output logic             out_valid,
   output logic [3:0]       exec_cmd,
   output logic             mem_read,
   output logic             mem_write,
   output logic             wb_en,
   output logic             imm,
   output logic             b,
   output logic             s_out,
   output logic [REG_W-1:0] out_rd,
   output logic             hazard
);

   // Decoded controls for the instruction currently in ID
   logic [3:0] d_cmd;
   logic       d_mr;
   logic       d_mw;
   logic       d_wb;
   logic       d_b;
   logic       d_s;
   logic       d_imm;

   always_comb begin
      d_cmd = 4'b1111;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_wb  = 1'b0;
      d_b   = 1'b0;
      d_s   = 1'b0;
      d_imm = i_in;
      unique case (mode)
         2'b00: begin
            d_s  = s_in;
            d_wb = 1'b1;
            unique case (opcode)
               4'b1101: d_cmd = 4'b0001;
               4'b1111: d_cmd = 4'b1001;
               4'b0100: d_cmd = 4'b0010;
               4'b0101: d_cmd = 4'b0011;
               4'b0010: d_cmd = 4'b0100;
               4'b0110: d_cmd = 4'b0101;
               4'b0000: d_cmd = 4'b0110;
               4'b1100: d_cmd = 4'b0111;
               4'b0001: d_cmd = 4'b1000;
               4'b1010: begin
                  d_cmd = 4'b0100;
                  d_wb  = 1'b0;
               end
               4'b1000: begin
                  d_cmd = 4'b0110;
                  d_wb  = 1'b0;
               end
               default: begin
                  d_cmd = 4'b1111;
                  d_wb  = 1'b0;
               end
            endcase
         end
         2'b01: begin
            d_cmd = 4'b0010;
            d_mr  = s_in;
            d_mw  = ~s_in;
            d_wb  = s_in;
         end
         2'b10: begin
            d_b  = 1'b1;
            d_wb = 1'b0;
         end
         default: begin
            d_wb = 1'b1;
         end
      endcase
   end

   // Scoreboard: entry 0 mirrors ID/EX, higher entries are older
   logic [HAZ_DEPTH-1:0] sb_v;
   logic [HAZ_DEPTH-1:0] sb_wb;
   logic [REG_W-1:0]     sb_rd [HAZ_DEPTH];

   logic [HAZ_DEPTH-1:0] match;

   always_comb begin
      match = '0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         match[i] = sb_v[i] && sb_wb[i] &&
                    ((sb_rd[i] == rn) ||
                     (two_src && (sb_rd[i] == rm)));
      end
   end

`ifdef CTRL_FORWARDING_EN
   // Only a load in ID/EX cannot be forwarded in time;
   // mem_read is the ld bit of entry 0.
   assign hazard = in_valid && match[0] && mem_read;
`else
   assign hazard = in_valid && (|match);
`endif

   // flush drops the ID instruction, so it counts as consumed
   logic accept;

   assign accept   = !hold && !flush && in_valid && !hazard;
   assign in_ready = !hold && (flush || (in_valid && !hazard));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         exec_cmd  <= 4'b0000;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         wb_en     <= 1'b0;
         imm       <= 1'b0;
         b         <= 1'b0;
         s_out     <= 1'b0;
         out_rd    <= '0;
      end else if (!hold) begin
         if (accept) begin
            out_valid <= 1'b1;
            exec_cmd  <= d_cmd;
            mem_read  <= d_mr;
            mem_write <= d_mw;
            wb_en     <= d_wb;
            imm       <= d_imm;
            b         <= d_b;
            s_out     <= d_s;
            out_rd    <= rd;
         end else begin
            out_valid <= 1'b0;
            exec_cmd  <= 4'b0000;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            wb_en     <= 1'b0;
            imm       <= 1'b0;
            b         <= 1'b0;
            s_out     <= 1'b0;
            out_rd    <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_v  <= '0;
         sb_wb <= '0;
         for (int i = 0; i < HAZ_DEPTH; i++) begin
            sb_rd[i] <= '0;
         end
      end else if (!hold) begin
         sb_v[0]  <= accept;
         sb_wb[0] <= accept && d_wb;
         sb_rd[0] <= accept ? rd : '0;
         for (int i = 1; i < HAZ_DEPTH; i++) begin
            sb_v[i]  <= sb_v[i-1];
            sb_wb[i] <= sb_wb[i-1];
            sb_rd[i] <= sb_rd[i-1];
         end
      end
   end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: directed and random checks of ctrl_decode_pipe
// against a queue-based reference model of the pipeline.

module tb_ctrl_decode_pipe;

   localparam int HD = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] mode = '0;
   logic [3:0] opcode = '0;
   logic       s_in = 1'b0;
   logic       i_in = 1'b0;
   logic [3:0] rd = '0;
   logic [3:0] rn = '0;
   logic [3:0] rm = '0;
   logic       two_src = 1'b0;
   logic       hold = 1'b0;
   logic       flush = 1'b0;

   logic       in_ready;
   logic       out_valid;
   logic [3:0] exec_cmd;
   logic       mem_read;
   logic       mem_write;
   logic       wb_en;
   logic       imm;
   logic       b;
   logic       s_out;
   logic [3:0] out_rd;
   logic       hazard;

   always #5 clk = ~clk;

   ctrl_decode_pipe #(.REG_W(4), .HAZ_DEPTH(HD)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .opcode(opcode), .s_in(s_in), .i_in(i_in),
      .rd(rd), .rn(rn), .rm(rm), .two_src(two_src),
      .hold(hold), .flush(flush),
      .out_valid(out_valid), .exec_cmd(exec_cmd),
      .mem_read(mem_read), .mem_write(mem_write),
      .wb_en(wb_en), .imm(imm), .b(b), .s_out(s_out),
      .out_rd(out_rd), .hazard(hazard)
   );

   logic [14:0] outv;
   assign outv = {out_valid, exec_cmd, mem_read, mem_write,
                  wb_en, imm, b, s_out, out_rd};

   int n_vec = 0;
   int n_err = 0;

   task automatic check(string tag, logic [31:0] obs,
                        logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       v;
      logic       wb;
      logic       ld;
      logic [3:0] rd;
   } ent_t;

   ent_t        q[$];
   logic [14:0] exp_out;
   logic        m_rdy;
   int          rd_log[$];

   // {v, cmd, mem_read, mem_write, wb, imm, b, s, rd}
   function automatic logic [14:0] ref_dec(logic [1:0] md,
      logic [3:0] op, logic s, logic i, logic [3:0] r);
      logic [3:0] c;
      logic       w;
      c = 4'd15;
      w = 1'b1;
      if (md == 2'd0) begin
         case (op)
            4'd13: c = 4'd1;
            4'd15: c = 4'd9;
            4'd4:  c = 4'd2;
            4'd5:  c = 4'd3;
            4'd2:  c = 4'd4;
            4'd6:  c = 4'd5;
            4'd0:  c = 4'd6;
            4'd12: c = 4'd7;
            4'd1:  c = 4'd8;
            4'd10: c = 4'd4;
            4'd8:  c = 4'd6;
            default: begin
               c = 4'd15;
               w = 1'b0;
            end
         endcase
         if (op == 4'd10 || op == 4'd8) w = 1'b0;
      end else if (md == 2'd1) begin
         c = 4'd2;
      end
      if (md == 2'd2 || (md == 2'd1 && !s)) w = 1'b0;
      return {1'b1, c, (md == 2'd1) && s, (md == 2'd1) && !s,
              w, i, md == 2'd2, (md == 2'd0) && s, r};
   endfunction

   function automatic logic m_haz();
      logic h;
      logic src;
      h = 1'b0;
      if (!in_valid) return 1'b0;
      foreach (q[k]) begin
         src = (q[k].rd == rn) || (two_src && (q[k].rd == rm));
`ifdef CTRL_FORWARDING_EN
         if (k == 0 && q[k].v && q[k].wb && q[k].ld && src) h = 1'b1;
`else
         if (q[k].v && q[k].wb && src) h = 1'b1;
`endif
      end
      return h;
   endfunction

   task automatic m_reset();
      ent_t e;
      e = '0;
      exp_out = '0;
      q.delete();
      for (int k = 0; k < HD; k++) q.push_back(e);
   endtask

   // One cycle: inputs were set at the falling edge
   task automatic step();
      logic mh;
      logic acc;
      logic [14:0] d;
      ent_t e;
      #2;
      mh = m_haz();
      m_rdy = !hold && (flush || (in_valid && !mh));
      check("hazard", hazard, mh);
      check("in_ready", in_ready, m_rdy);
      @(posedge clk);
      if (!hold) begin
         acc = in_valid && !flush && !mh;
         d = ref_dec(mode, opcode, s_in, i_in, rd);
         exp_out = acc ? d : '0;
         e.v  = acc;
         e.wb = acc && d[7];
         e.ld = acc && d[9];
         e.rd = acc ? rd : 4'd0;
         q.push_front(e);
         void'(q.pop_back());
      end
      #1;
      check("outs", outv, exp_out);
      if (!hold && out_valid) rd_log.push_back(int'(out_rd));
      @(negedge clk);
   endtask

   task automatic set_ins(logic [1:0] md, logic [3:0] op, logic s,
      logic i, logic [3:0] d, logic [3:0] n, logic [3:0] m,
      logic two);
      mode = md; opcode = op; s_in = s; i_in = i;
      rd = d; rn = n; rm = m; two_src = two;
      in_valid = 1'b1;
   endtask

   // Holds the instruction until consumed; counts stalled cycles
   task automatic issue(logic [1:0] md, logic [3:0] op, logic s,
      logic i, logic [3:0] d, logic [3:0] n, logic [3:0] m,
      logic two, output int stalls);
      set_ins(md, op, s, i, d, n, m, two);
      stalls = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (m_rdy) break;
         stalls++;
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(int n);
      in_valid = 1'b0;
      for (int k = 0; k < n; k++) step();
   endtask

   int st;
   int exp_lu;

   initial begin
`ifdef CTRL_FORWARDING_EN
      exp_lu = 1;
`else
      exp_lu = HD;
`endif
      m_reset();
      m_rdy = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_outs", outv, 15'd0);
      check("rst_hazard", hazard, 1'b0);
      rst_n = 1'b1;
      idle(1);

      // decode examples
      issue(2'd0, 4'b0100, 1'b1, 1'b0, 4'd3, 4'd1, 4'd0, 1'b0, st);
      check("add_v", out_valid, 1'b1);
      check("add_cmd", exec_cmd, 4'b0010);
      check("add_wb", wb_en, 1'b1);
      check("add_s", s_out, 1'b1);
      check("add_rd", out_rd, 4'd3);
      issue(2'd0, 4'b1010, 1'b1, 1'b0, 4'd7, 4'd8, 4'd0, 1'b0, st);
      check("cmp_wb", wb_en, 1'b0);
      check("cmp_cmd", exec_cmd, 4'b0100);
      issue(2'd1, 4'b0000, 1'b0, 1'b1, 4'd9, 4'd10, 4'd11, 1'b1, st);
      check("str_mw", mem_write, 1'b1);
      check("str_wb", wb_en, 1'b0);
      check("str_cmd", exec_cmd, 4'b0010);
      issue(2'd2, 4'b0000, 1'b0, 1'b0, 4'd12, 4'd13, 4'd0, 1'b0, st);
      check("b_b", b, 1'b1);
      check("b_cmd", exec_cmd, 4'b1111);
      idle(3);

      // load-use
      issue(2'd1, 4'd0, 1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 1'b0, st);
      issue(2'd0, 4'b0100, 1'b0, 1'b0, 4'd5, 4'd2, 4'd0, 1'b0, st);
      check("lu_bubbles", st, exp_lu);
      check("lu_add_v", out_valid, 1'b1);
      check("lu_add_rd", out_rd, 4'd5);
      idle(3);

      // hold mid-stream: no loss or duplication
      rd_log.delete();
      issue(2'd0, 4'b0100, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 1'b0, st);
      set_ins(2'd0, 4'b0100, 1'b0, 1'b0, 4'd6, 4'd0, 4'd0, 1'b0);
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 check("hold_rdy", in_ready, 1'b0);
         step();
         check("hold_rd", out_rd, 4'd5);
      end
      hold = 1'b0;
      issue(2'd0, 4'b0100, 1'b0, 1'b0, 4'd6, 4'd0, 4'd0, 1'b0, st);
      issue(2'd0, 4'b0100, 1'b0, 1'b0, 4'd7, 4'd0, 4'd0, 1'b0, st);
      idle(1);
      check("hold_cnt", rd_log.size(), 3);
      if (rd_log.size() == 3) begin
         check("hold_seq0", rd_log[0], 5);
         check("hold_seq1", rd_log[1], 6);
         check("hold_seq2", rd_log[2], 7);
      end
      idle(2);

      // flush together with hazard
      issue(2'd1, 4'd0, 1'b1, 1'b0, 4'd4, 4'd0, 4'd0, 1'b0, st);
      set_ins(2'd0, 4'b0100, 1'b0, 1'b0, 4'd1, 4'd4, 4'd0, 1'b0);
      flush = 1'b1;
      #1;
      check("fh_hazard", hazard, 1'b1);
      check("fh_rdy", in_ready, 1'b1);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fh_bubble", out_valid, 1'b0);
      issue(2'd0, 4'b0100, 1'b0, 1'b0, 4'd2, 4'd9, 4'd0, 1'b0, st);
      check("fh_next_st", st, 0);
      check("fh_next_v", out_valid, 1'b1);
      idle(3);

      // async reset while stalled
      issue(2'd1, 4'd0, 1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 1'b0, st);
      set_ins(2'd0, 4'b0100, 1'b0, 1'b0, 4'd6, 4'd2, 4'd0, 1'b0);
      step();
      #2 rst_n = 1'b0;
      #1;
      check("ar_outs", outv, 15'd0);
      check("ar_hazard", hazard, 1'b0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("ar_acc", out_valid, 1'b1);
      check("ar_rd", out_rd, 4'd6);
      in_valid = 1'b0;
      idle(1);

      // random stream
      m_rdy = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (!in_valid || m_rdy) begin
            set_ins(2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 3)),
                    4'($urandom_range(0, 3)),
                    4'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
            in_valid = ($urandom_range(0, 4) != 0);
         end
         hold  = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
